// File: rtl/cc_xfer_arbiter.sv
// Source-side controller for a shared toggle-handshake clock-crossing channel.
// Round-robin arbitration between NUM_REQ requesters; the winner's word is
// latched onto xfer_data and xfer_req toggles. The returning ack toggle
// (already synchronized) completes the transfer, followed by a forced gap.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | channel free, req_ready offers the round-robin winner
// WAIT_ACK | word launched, waiting for ack_sync to equal xfer_req
// GAP      | post-ack spacing, GAP_CYCLES cycles, then back to IDLE
module cc_xfer_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int WIDTH      = 8,
   parameter int SRC_W      = 2,
   parameter int TIMEOUT    = 255,
   parameter int GAP_CYCLES = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [WIDTH-1:0]         xfer_data,
   output logic [SRC_W-1:0]         xfer_src,
   output logic                     xfer_req,
   input  logic                     ack_sync,
   output logic                     done,
   output logic [SRC_W-1:0]         done_src,
   output logic                     busy,
   output logic                     timeout,
   input  logic                     timeout_clr
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam int GAP_W = 8;

   typedef enum logic [1:0] {IDLE, WAIT_ACK, GAP} state_t;

   state_t             state_q, state_d;
   logic [SRC_W-1:0]   ptr_q;
   logic [SRC_W-1:0]   win;
   logic [WIDTH-1:0]   win_data;
   logic               any_valid;
   logic               accept;
   logic               ack_match;
   logic               tmo_hit;
   logic [CNT_W-1:0]   wait_cnt_q;
   logic [GAP_W-1:0]   gap_cnt_q;

   // Round-robin pick: first valid above the pointer, then wrap to the lowest.
   always_comb begin
      any_valid = 1'b0;
      win       = '0;
      win_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!any_valid && req_valid[i] && (i > int'(ptr_q))) begin
            any_valid = 1'b1;
            win       = SRC_W'(i);
            win_data  = req_data[i*WIDTH +: WIDTH];
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!any_valid && req_valid[i] && (i <= int'(ptr_q))) begin
            any_valid = 1'b1;
            win       = SRC_W'(i);
            win_data  = req_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Next state and grant; reset suppresses any grant in the same cycle.
   always_comb begin
      state_d   = state_q;
      req_ready = '0;
      accept    = 1'b0;
      ack_match = (ack_sync == xfer_req);
      tmo_hit   = (wait_cnt_q == CNT_W'(TIMEOUT - 1));
      case (state_q)
         IDLE: begin
            if (rst_n && any_valid) begin
               for (int i = 0; i < NUM_REQ; i++) begin
                  req_ready[i] = (int'(win) == i);
               end
               accept  = 1'b1;
               state_d = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (ack_match) begin
               state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
            end
         end
         GAP: begin
            if (gap_cnt_q == '0) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Launch, completion, gap down-counter and sticky timeout flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         xfer_data  <= '0;
         xfer_src   <= '0;
         xfer_req   <= 1'b0;
         done       <= 1'b0;
         done_src   <= '0;
         timeout    <= 1'b0;
         ptr_q      <= SRC_W'(NUM_REQ - 1);
         wait_cnt_q <= '0;
         gap_cnt_q  <= '0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            xfer_data  <= win_data;
            xfer_src   <= win;
            xfer_req   <= ~xfer_req;
            ptr_q      <= win;
            wait_cnt_q <= '0;
         end
         if (state_q == WAIT_ACK) begin
            if (wait_cnt_q != CNT_W'(TIMEOUT)) begin
               wait_cnt_q <= wait_cnt_q + 1'b1;
            end
            if (ack_match) begin
               done      <= 1'b1;
               done_src  <= xfer_src;
               gap_cnt_q <= GAP_W'(GAP_CYCLES - 1);
            end
         end
         if ((state_q == GAP) && (gap_cnt_q != '0)) begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
         end
         // A set on the same edge as a clear takes priority.
         if ((state_q == WAIT_ACK) && tmo_hit) begin
            timeout <= 1'b1;
         end else if (timeout_clr) begin
            timeout <= 1'b0;
         end
      end
   end

   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_cc_xfer_arbiter.sv
// Bench for cc_xfer_arbiter: timestamp-based reference model checked every
// cycle, a done-driven scoreboard, and a destination domain on its own clock
// that synchronizes the toggle/data and returns a synchronized ack.
`timescale 1ns/1ps
module tb_cc_xfer_arbiter;

   localparam int NUM_REQ = 4;
   localparam int WIDTH   = 8;
   localparam int SRC_W   = 2;
   localparam int TIMEOUT = 255;
   localparam int GAP     = 2;
   localparam int INF     = 32'h7fffffff;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic [NUM_REQ-1:0]       req_valid = '0;
   logic [NUM_REQ*WIDTH-1:0] req_data = '0;
   logic [NUM_REQ-1:0]       req_ready;
   logic [WIDTH-1:0]         xfer_data;
   logic [SRC_W-1:0]         xfer_src;
   logic                     xfer_req;
   logic                     ack_sync;
   logic                     done;
   logic [SRC_W-1:0]         done_src;
   logic                     busy;
   logic                     timeout;
   logic                     timeout_clr = 1'b0;

   logic ack_man = 1'b0;
   logic manual  = 1'b1;
   logic ack_loop;
   assign ack_sync = manual ? ack_man : ack_loop;

   int total = 0;
   int bad   = 0;

   cc_xfer_arbiter #(
      .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .SRC_W(SRC_W),
      .TIMEOUT(TIMEOUT), .GAP_CYCLES(GAP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .xfer_data(xfer_data), .xfer_src(xfer_src),
      .xfer_req(xfer_req), .ack_sync(ack_sync), .done(done),
      .done_src(done_src), .busy(busy), .timeout(timeout),
      .timeout_clr(timeout_clr)
   );

   always #6 clk = ~clk;

   int   dst_half = 18;
   logic dst_clk = 1'b0;
   initial begin
      #1;
      forever #(dst_half) dst_clk = ~dst_clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- destination domain ----------------
   logic [WIDTH-1:0] d1 = '0, d2 = '0;
   logic             s1 = 1'b0, s2 = 1'b0, dack = 1'b0, a1 = 1'b0;
   logic [WIDTH-1:0] rx_q [$];

   always @(posedge dst_clk) begin
      if (!rst_n) begin
         s1 <= 1'b0; s2 <= 1'b0; d1 <= '0; d2 <= '0; dack <= 1'b0;
      end else begin
         s1 <= xfer_req; d1 <= xfer_data;
         s2 <= s1;       d2 <= d1;
         if (s2 != dack) begin
            dack <= s2;
            rx_q.push_back(d2);
         end
      end
   end

   initial ack_loop = 1'b0;
   always @(posedge clk) begin
      if (!rst_n) begin
         a1 <= 1'b0; ack_loop <= 1'b0;
      end else begin
         a1 <= dack; ack_loop <= a1;
      end
   end

   // ---------------- reference model ----------------
   typedef struct { int src; logic [WIDTH-1:0] data; } exp_t;
   exp_t exp_q [$];

   int  cyc = 0;
   bit  chk_en = 1'b0;
   int  m_idle_at = 0, m_acc = 0, m_done_at = -1, m_ptr = NUM_REQ - 1, m_src = 0;
   bit  m_wait = 1'b0, m_lvl = 1'b0, m_to = 1'b0, to_set;
   logic [WIDTH-1:0]   m_data = '0;
   logic [NUM_REQ-1:0] exp_rdy;
   logic [NUM_REQ-1:0] hs = '0;
   int  win_m, w;
   int  n_done = 0;

   always @(posedge clk) begin
      cyc++;
      if (!rst_n) begin
         exp_q.delete();
         rx_q.delete();
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         hs      = req_ready & req_valid;
         exp_rdy = '0;
         win_m   = -1;
         if (rst_n && cyc >= m_idle_at) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
               w = (m_ptr + k) % NUM_REQ;
               if (win_m < 0 && req_valid[w]) win_m = w;
            end
         end
         if (win_m >= 0) exp_rdy[win_m] = 1'b1;
         chk("req_ready", req_ready, exp_rdy);
         chk("busy", busy, cyc < m_idle_at);
         chk("xfer_req", xfer_req, m_lvl);
         chk("xfer_src", xfer_src, m_src);
         chk("xfer_data", xfer_data, m_data);
         chk("done", done, cyc == m_done_at);
         if (cyc == m_done_at) chk("done_src", done_src, m_src);
         chk("timeout", timeout, m_to);
         to_set = 1'b0;
         if (!rst_n) begin
            m_idle_at = cyc + 1; m_lvl = 1'b0; m_src = 0; m_data = '0;
            m_ptr = NUM_REQ - 1; m_wait = 1'b0; m_done_at = -1; m_to = 1'b0;
         end else begin
            if (m_wait) begin
               if (cyc - m_acc == TIMEOUT) to_set = 1'b1;
               if (ack_sync == m_lvl) begin
                  m_wait    = 1'b0;
                  m_done_at = cyc + 1;
                  m_idle_at = cyc + 1 + GAP;
               end
            end
            if (win_m >= 0) begin
               m_ptr = win_m; m_src = win_m;
               m_data = req_data[win_m*WIDTH +: WIDTH];
               exp_q.push_back('{win_m, req_data[win_m*WIDTH +: WIDTH]});
               m_lvl = ~m_lvl; m_acc = cyc; m_wait = 1'b1; m_idle_at = INF;
            end
            m_to = to_set ? 1'b1 : (timeout_clr ? 1'b0 : m_to);
         end
      end
   end

   // ---------------- scoreboard monitor ----------------
   exp_t e;
   always @(negedge clk) begin
      if (chk_en && done === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_done", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("sb_src", done_src, e.src);
            if (!manual) begin
               if (rx_q.size() == 0) chk("sb_rx_missing", 1, 0);
               else                  chk("sb_data", rx_q.pop_front(), e.data);
            end
            n_done++;
         end
      end
   end

   // ---------------- stimulus ----------------
   int               pend [NUM_REQ];
   logic [WIDTH-1:0] dat  [NUM_REQ];
   bit               drop_en = 1'b0;
   logic             last_lvl = 1'b0;

   task automatic step();
      @(posedge clk); #1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (hs[i]) begin
            pend[i]--;
            dat[i] = WIDTH'($urandom);
         end else if (drop_en && $urandom_range(0, 3) == 0) begin
            dat[i] = WIDTH'($urandom);
         end
         req_valid[i] = (pend[i] > 0) && (!drop_en || $urandom_range(0, 3) != 0);
         req_data[i*WIDTH +: WIDTH] = dat[i];
      end
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0; ack_man = 1'b0;
      repeat (n) step();
      rst_n = 1'b1; last_lvl = 1'b0;
   endtask

   task automatic wait_acc();
      int n = 0;
      do begin step(); n++; end while (xfer_req == last_lvl && n < 100);
      chk("accept_seen", xfer_req != last_lvl, 1);
      last_lvl = xfer_req;
   endtask

   task automatic give_ack(input int dly);
      repeat (dly) step();
      ack_man = last_lvl;
   endtask

   task automatic man_xfer(input int src, input int dly);
      wait_acc();
      chk("grant_order", xfer_src, src);
      give_ack(dly);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int planned, n;
      for (int i = 0; i < NUM_REQ; i++) begin pend[i] = 1; dat[i] = WIDTH'(8'h10 + i); end
      @(posedge clk); #1;
      chk_en = 1'b1;

      // reset with everyone requesting, then release
      repeat (4) step();
      chk("rst_ready", req_ready, 0);
      chk("rst_xfer_req", xfer_req, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      man_xfer(0, 5);
      chk("rel_xfer_req", xfer_req, 1);
      for (int k = 1; k < NUM_REQ; k++) man_xfer(k, 3);

      // single transfer from requester 1
      pend[1] = 1; dat[1] = 8'hA5;
      man_xfer(1, 5);
      chk("single_data", xfer_data, 8'hA5);
      step();
      chk("single_done", done, 1);
      chk("single_done_src", done_src, 1);
      repeat (GAP) step();
      chk("single_idle", busy, 0);

      // round robin with all requesters continuously valid
      for (int i = 0; i < NUM_REQ; i++) pend[i] = 2;
      do_reset(3);
      for (int k = 0; k < 2 * NUM_REQ; k++) man_xfer(k % NUM_REQ, $urandom_range(1, 6));
      repeat (8) step();

      // timeout: set, hold while waiting, ack, clear; then clear on the set cycle
      pend[0] = 1;
      do_reset(3);
      wait_acc();
      repeat (TIMEOUT - 1) step();
      chk("to_early", timeout, 0);
      step();
      chk("to_set", timeout, 1);
      chk("to_busy", busy, 1);
      give_ack(4);
      repeat (4) step();
      chk("to_sticky", timeout, 1);
      timeout_clr = 1'b1; step(); timeout_clr = 1'b0;
      chk("to_clr", timeout, 0);
      pend[2] = 1;
      wait_acc();
      repeat (TIMEOUT - 1) step();
      timeout_clr = 1'b1; step(); timeout_clr = 1'b0;
      chk("to_set_wins", timeout, 1);
      give_ack(2);
      repeat (6) step();

      // reset in the middle of WAIT_ACK abandons the transfer
      pend[3] = 1;
      do_reset(3);
      wait_acc();
      repeat (3) step();
      pend[3] = 0;
      rst_n = 1'b0; ack_man = 1'b0;
      repeat (3) step();
      chk("mr_xfer_req", xfer_req, 0);
      chk("mr_busy", busy, 0);
      rst_n = 1'b1;
      repeat (10) step();

      // closed loop through the destination domain, slow then fast
      for (int r = 0; r < 2; r++) begin
         dst_half = (r == 0) ? 18 : 2;
         manual = 1'b0;
         for (int i = 0; i < NUM_REQ; i++) pend[i] = 0;
         do_reset(12);
         planned = 0;
         for (int i = 0; i < NUM_REQ; i++) begin
            pend[i] = $urandom_range(3, 6);
            planned += pend[i];
         end
         n_done = 0;
         drop_en = 1'b1;
         n = 0;
         while ((n_done < planned) && n < 5000) begin step(); n++; end
         chk("cl_words", n_done, planned);
         drop_en = 1'b0;
         repeat (10) step();
         manual = 1'b1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
